// File: rtl/mem_wb_stage_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_pkg
//  Description : Shared types and default widths for the elastic MEM->WB
//                pipeline stage buffer.
//                - mem_wb_ctrl_t : writeback/load/store control bundle
//                - DATA_W_DEF    : default data word width
//                - DEST_W_DEF    : default destination register index width
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEST_W_DEF = 4;

    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
    } mem_wb_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_buf_if
//  Description : Handshake and payload bundle of the MEM->WB stage buffer.
//                Upstream side : in_valid/in_ready, in_wb_en, in_mem_r_en,
//                                in_mem_w_en, in_data, in_dest
//                Downstream    : out_valid/out_ready, out_wb_en, out_mem_r_en,
//                                out_mem_w_en, out_data, out_dest
//                modport slave  - used by the buffer itself
//                modport master - used by the environment driving the buffer
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_buf_if
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic              in_wb_en;
    logic              in_mem_r_en;
    logic              in_mem_w_en;
    logic [DATA_W-1:0] in_data;
    logic [DEST_W-1:0] in_dest;

    logic              out_valid;
    logic              out_ready;
    logic              out_wb_en;
    logic              out_mem_r_en;
    logic              out_mem_w_en;
    logic [DATA_W-1:0] out_data;
    logic [DEST_W-1:0] out_dest;

    modport slave (
        input  in_valid, in_wb_en, in_mem_r_en, in_mem_w_en, in_data, in_dest,
        output in_ready,
        input  out_ready,
        output out_valid, out_wb_en, out_mem_r_en, out_mem_w_en, out_data, out_dest
    );

    modport master (
        output in_valid, in_wb_en, in_mem_r_en, in_mem_w_en, in_data, in_dest,
        input  in_ready,
        output out_ready,
        input  out_valid, out_wb_en, out_mem_r_en, out_mem_w_en, out_data, out_dest
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage_buf_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_ptr_ctrl
//  Description : Pointer/count bookkeeping of the MEM->WB stage buffer.
//                Owns read/write pointers (wrapping at DEPTH-1, so any DEPTH
//                works), the entry count, flush/freeze handling and the
//                ready/valid terms.
//  Ports       : clk, rst (sync, active-low), freeze, flush
//                in_valid, out_ready            - handshake requests
//                in_ready, out_valid            - handshake grants
//                push                           - storage write strobe
//                wr_ptr, rd_ptr                 - storage addresses
//                count                          - stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_ptr_ctrl #(
    parameter int DEPTH = 2,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             push,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [OCC_W-1:0] count
);
    localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);

    logic [OCC_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_pop;

    // Ready looks only at the registered count: a pop in the same cycle does
    // not open a slot, which keeps out_ready off the in_ready path.
    assign in_ready  = rst & ~freeze & ~flush & (r_count < C_DEPTH);
    assign out_valid = rst & ~freeze & (r_count != '0);
    assign push      = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == C_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (!freeze) begin
            if (push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
            case ({push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign wr_ptr = r_wr_ptr;
    assign rd_ptr = r_rd_ptr;
    assign count  = r_count;
endmodule
`default_nettype wire

// File: rtl/mem_wb_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_buf
//  Description : Elastic DEPTH-entry in-order MEM->WB pipeline buffer with
//                valid/ready on both sides, global freeze and flush.
//                Optional macro MEM_WB_PERF_CNT_EN adds a saturating stall
//                counter (stall_cnt) counting cycles where in_valid is held
//                off by in_ready=0; cleared only by reset.
//  Ports       : clk, rst (sync, active-low), freeze, flush
//                bus       - mem_wb_stage_buf_if.slave handshake/payload
//                occupancy - number of stored entries
//                stall_cnt - (MEM_WB_PERF_CNT_EN only) stall cycle counter
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage_buf
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         freeze,
    input  logic                         flush,
    mem_wb_stage_buf_if.slave            bus,
`ifdef MEM_WB_PERF_CNT_EN
    output logic [CNT_W-1:0]             stall_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic [PTR_W-1:0]  w_wr_ptr;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic [OCC_W-1:0]  w_count;

    mem_wb_ctrl_t      w_in_ctrl;
    mem_wb_ctrl_t      w_head_ctrl;

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEST_W-1:0] r_dest [DEPTH];
    mem_wb_ctrl_t      r_ctrl [DEPTH];

    mem_wb_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .OCC_W (OCC_W)
    ) u_ptr_ctrl (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (w_in_ready),
        .out_valid (w_out_valid),
        .push      (w_push),
        .wr_ptr    (w_wr_ptr),
        .rd_ptr    (w_rd_ptr),
        .count     (w_count)
    );

    assign w_in_ctrl.wb_en    = bus.in_wb_en;
    assign w_in_ctrl.mem_r_en = bus.in_mem_r_en;
    assign w_in_ctrl.mem_w_en = bus.in_mem_w_en;

    // Storage needs no reset: every read is gated by out_valid, which is only
    // set for slots written since the last reset/flush.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[w_wr_ptr] <= bus.in_data;
            r_dest[w_wr_ptr] <= bus.in_dest;
            r_ctrl[w_wr_ptr] <= w_in_ctrl;
        end
    end

    assign w_head_ctrl      = r_ctrl[w_rd_ptr];

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_wb_en    = w_out_valid & w_head_ctrl.wb_en;
    assign bus.out_mem_r_en = w_out_valid & w_head_ctrl.mem_r_en;
    assign bus.out_mem_w_en = w_out_valid & w_head_ctrl.mem_w_en;
    assign bus.out_data     = w_out_valid ? r_data[w_rd_ptr] : '0;
    assign bus.out_dest     = w_out_valid ? r_dest[w_rd_ptr] : '0;
    assign occupancy        = w_count;

`ifdef MEM_WB_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (bus.in_valid && !w_in_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage_buf
//  Description : Self-checking bench for mem_wb_stage_buf. Two instances
//                (DEPTH=2 and DEPTH=3) share one stimulus stream; each is
//                compared every cycle against a queue-based reference model,
//                plus a table of hand-derived vectors for the DEPTH=2 part.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage_buf;
    import mem_wb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, freeze, flush, in_valid, out_ready;
    logic [2:0]  in_ctrl;
    logic [3:0]  in_dest;
    logic [31:0] in_data;

    mem_wb_stage_buf_if #(.DATA_W(32), .DEST_W(4)) bus2 ();
    mem_wb_stage_buf_if #(.DATA_W(32), .DEST_W(4)) bus3 ();

    assign bus2.in_valid    = in_valid;
    assign bus2.in_wb_en    = in_ctrl[2];
    assign bus2.in_mem_r_en = in_ctrl[1];
    assign bus2.in_mem_w_en = in_ctrl[0];
    assign bus2.in_data     = in_data;
    assign bus2.in_dest     = in_dest;
    assign bus2.out_ready   = out_ready;
    assign bus3.in_valid    = in_valid;
    assign bus3.in_wb_en    = in_ctrl[2];
    assign bus3.in_mem_r_en = in_ctrl[1];
    assign bus3.in_mem_w_en = in_ctrl[0];
    assign bus3.in_data     = in_data;
    assign bus3.in_dest     = in_dest;
    assign bus3.out_ready   = out_ready;

    logic [1:0] occ2;
    logic [2:0] occ3;
`ifdef MEM_WB_PERF_CNT_EN
    logic [31:0] stall2, stall3;
`endif

    mem_wb_stage_buf #(.DATA_W(32), .DEST_W(4), .DEPTH(2), .CNT_W(32)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .flush     (flush),
        .bus       (bus2),
`ifdef MEM_WB_PERF_CNT_EN
        .stall_cnt (stall2),
`endif
        .occupancy (occ2)
    );

    mem_wb_stage_buf #(.DATA_W(32), .DEST_W(4), .DEPTH(3), .CNT_W(32)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .flush     (flush),
        .bus       (bus3),
`ifdef MEM_WB_PERF_CNT_EN
        .stall_cnt (stall3),
`endif
        .occupancy (occ3)
    );

    // ---------------- reference model: one FIFO queue per instance ---------
    typedef struct packed {
        logic [2:0]  ctrl;
        logic [3:0]  dest;
        logic [31:0] data;
    } ent_t;

    ent_t        q2[$];
    ent_t        q3[$];
    int unsigned ms2, ms3;
    int          vectors;
    int          miscompares;

    // {in_ready, out_valid, ctrl[2:0], occupancy[3:0], dest[3:0], data[31:0]}
    function automatic logic [44:0] act_vec(input int which);
        if (which == 2)
            return {bus2.in_ready, bus2.out_valid, bus2.out_wb_en, bus2.out_mem_r_en,
                    bus2.out_mem_w_en, 2'b00, occ2, bus2.out_dest, bus2.out_data};
        return {bus3.in_ready, bus3.out_valid, bus3.out_wb_en, bus3.out_mem_r_en,
                bus3.out_mem_w_en, 1'b0, occ3, bus3.out_dest, bus3.out_data};
    endfunction

    task automatic model_check(input int which);
        int          sz;
        int          depth;
        ent_t        head;
        logic        ir, ov;
        logic [44:0] exp_v, act_v, mask;
        if (which == 2) begin
            sz = q2.size(); depth = 2; head = (sz > 0) ? q2[0] : '0;
        end else begin
            sz = q3.size(); depth = 3; head = (sz > 0) ? q3[0] : '0;
        end
        ir    = rst && !freeze && !flush && (sz < depth);
        ov    = rst && !freeze && (sz > 0);
        exp_v = {ir, ov, ov ? head.ctrl : 3'b000, 4'(sz),
                 ov ? head.dest : 4'h0, ov ? head.data : 32'h0};
        mask  = '1;
        // Frozen but non-empty: data/dest are not defined by the interface.
        if (rst && !ov && sz > 0) mask[35:0] = '0;
        act_v = act_vec(which);
        vectors++;
        if ((act_v & mask) !== (exp_v & mask)) begin
            miscompares++;
            $display("FAIL model_dut%0d t=%0t: got %h expected %h (mask %h)",
                     which, $time, act_v, exp_v, mask);
        end
`ifdef MEM_WB_PERF_CNT_EN
        vectors++;
        if (which == 2 && stall2 !== ms2) begin
            miscompares++;
            $display("FAIL stall_dut2 t=%0t: got %0d expected %0d", $time, stall2, ms2);
        end
        if (which == 3 && stall3 !== ms3) begin
            miscompares++;
            $display("FAIL stall_dut3 t=%0t: got %0d expected %0d", $time, stall3, ms3);
        end
`endif
    endtask

    // Sample outputs on the falling edge, with inputs set after the last rise.
    task automatic pre();
        @(negedge clk);
        model_check(2);
        model_check(3);
    endtask

    // Apply the buffer rules to the model queues across one rising edge.
    task automatic post();
        ent_t e;
        logic ir2, ov2, ir3, ov3;
        e   = {in_ctrl, in_dest, in_data};
        ir2 = rst && !freeze && !flush && (q2.size() < 2);
        ov2 = rst && !freeze && (q2.size() > 0);
        ir3 = rst && !freeze && !flush && (q3.size() < 3);
        ov3 = rst && !freeze && (q3.size() > 0);
        @(posedge clk);
        if (!rst) begin
            q2.delete(); q3.delete(); ms2 = 0; ms3 = 0;
        end else begin
            if (flush) begin
                q2.delete(); q3.delete();
            end else begin
                if (ov2 && out_ready) void'(q2.pop_front());
                if (in_valid && ir2) q2.push_back(e);
                if (ov3 && out_ready) void'(q3.pop_front());
                if (in_valid && ir3) q3.push_back(e);
            end
            if (in_valid && !ir2 && ms2 != 32'hFFFF_FFFF) ms2++;
            if (in_valid && !ir3 && ms3 != 32'hFFFF_FFFF) ms3++;
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic fz, input logic fl, input logic iv,
                         input logic ordy, input logic [2:0] c, input logic [3:0] d,
                         input logic [31:0] w);
        rst = r; freeze = fz; flush = fl; in_valid = iv; out_ready = ordy;
        in_ctrl = c; in_dest = d; in_data = w;
    endtask

    // ---------------- hand-derived table for the DEPTH=2 instance ----------
    typedef struct {
        logic        rst, fz, fl, iv, ordy;
        logic [2:0]  ctrl;
        logic [3:0]  dest;
        logic [31:0] data;
        logic        e_ir, e_ov;
        logic [2:0]  e_ctrl;
        logic [1:0]  e_occ;
        logic [3:0]  e_dest;
        logic [31:0] e_data;
        logic        chk_pay;
    } row_t;

    row_t rows[21];

    function automatic row_t mk(input logic r, input logic fz, input logic fl, input logic iv,
                                input logic ordy, input logic [2:0] c, input logic [3:0] d,
                                input logic [31:0] w, input logic eir, input logic eov,
                                input logic [2:0] ec, input logic [1:0] eo,
                                input logic [3:0] ed, input logic [31:0] ew, input logic cp);
        row_t x;
        x.rst = r; x.fz = fz; x.fl = fl; x.iv = iv; x.ordy = ordy;
        x.ctrl = c; x.dest = d; x.data = w;
        x.e_ir = eir; x.e_ov = eov; x.e_ctrl = ec; x.e_occ = eo;
        x.e_dest = ed; x.e_data = ew; x.chk_pay = cp;
        return x;
    endfunction

    initial begin
        logic [44:0] a, e;
        vectors = 0; miscompares = 0; ms2 = 0; ms3 = 0;

        // reset held with in_valid high
        rows[0]  = mk(0,0,0,1,0, 3'b111, 4'hF, 32'hFFFF_FFFF, 0,0,3'b000,0,4'h0,32'h0,1);
        rows[1]  = rows[0];
        rows[2]  = rows[0];
        rows[3]  = mk(1,0,0,0,0, 3'b000, 4'h0, 32'h0,         1,0,3'b000,0,4'h0,32'h0,1);
        // fill to full, full blocks a push even with a concurrent pop, drain in order
        rows[4]  = mk(1,0,0,1,0, 3'b110, 4'h3, 32'hA5A5_0001, 1,0,3'b000,0,4'h0,32'h0,1);
        rows[5]  = mk(1,0,0,1,0, 3'b101, 4'h4, 32'hA5A5_0002, 1,1,3'b110,1,4'h3,32'hA5A5_0001,1);
        rows[6]  = mk(1,0,0,0,0, 3'b000, 4'h0, 32'h0,         0,1,3'b110,2,4'h3,32'hA5A5_0001,1);
        rows[7]  = mk(1,0,0,1,0, 3'b011, 4'h9, 32'hDEAD_0007, 0,1,3'b110,2,4'h3,32'hA5A5_0001,1);
        rows[8]  = mk(1,0,0,1,1, 3'b011, 4'h9, 32'hDEAD_0008, 0,1,3'b110,2,4'h3,32'hA5A5_0001,1);
        rows[9]  = mk(1,0,0,0,1, 3'b000, 4'h0, 32'h0,         1,1,3'b101,1,4'h4,32'hA5A5_0002,1);
        rows[10] = mk(1,0,0,0,0, 3'b000, 4'h0, 32'h0,         1,0,3'b000,0,4'h0,32'h0,1);
        // freeze with one entry held for 4 cycles, then it pops
        rows[11] = mk(1,0,0,1,0, 3'b100, 4'h5, 32'h0000_0011, 1,0,3'b000,0,4'h0,32'h0,1);
        rows[12] = mk(1,1,0,1,1, 3'b001, 4'h7, 32'h0000_0022, 0,0,3'b000,1,4'h0,32'h0,0);
        rows[13] = rows[12];
        rows[14] = rows[12];
        rows[15] = rows[12];
        rows[16] = mk(1,0,0,0,1, 3'b000, 4'h0, 32'h0,         1,1,3'b100,1,4'h5,32'h0000_0011,1);
        rows[17] = mk(1,0,0,0,0, 3'b000, 4'h0, 32'h0,         1,0,3'b000,0,4'h0,32'h0,1);
        // flush beats freeze and drops the concurrent in_valid
        rows[18] = mk(1,0,0,1,0, 3'b010, 4'h6, 32'h0000_0033, 1,0,3'b000,0,4'h0,32'h0,1);
        rows[19] = mk(1,1,1,1,0, 3'b111, 4'h8, 32'h0000_0044, 0,0,3'b000,1,4'h0,32'h0,0);
        rows[20] = mk(1,0,0,0,0, 3'b000, 4'h0, 32'h0,         1,0,3'b000,0,4'h0,32'h0,1);

        drive(0,0,0,0,0, 3'b000, 4'h0, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 21; i++) begin
            drive(rows[i].rst, rows[i].fz, rows[i].fl, rows[i].iv, rows[i].ordy,
                  rows[i].ctrl, rows[i].dest, rows[i].data);
            pre();
            a = act_vec(2);
            e = {rows[i].e_ir, rows[i].e_ov, rows[i].e_ctrl, 2'b00, rows[i].e_occ,
                 rows[i].e_dest, rows[i].e_data};
            if (!rows[i].chk_pay) begin a[35:0] = '0; e[35:0] = '0; end
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL row%0d: got %h expected %h", i, a, e);
            end
            post();
        end

        // streaming: one result per cycle, one cycle late, no bubbles
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) drive(1,0,0,1,1, 3'b100, 4'(i), 32'(i));
            else        drive(1,0,0,0,1, 3'b000, 4'h0, 32'h0);
            pre();
            vectors++;
            if (i == 0) begin
                if (bus2.out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream%0d: got valid %b expected 0", i, bus2.out_valid);
                end
            end else if (bus2.out_valid !== 1'b1 || bus2.out_data !== 32'(i - 1)) begin
                miscompares++;
                $display("FAIL stream%0d: got valid %b data %h expected 1 %h",
                         i, bus2.out_valid, bus2.out_data, 32'(i - 1));
            end
            post();
        end

        // interleaved traffic so the DEPTH=3 pointers wrap more than once
        for (int k = 0; k < 10; k++) begin
            if (k < 2)      drive(1,0,0,1,0, 3'b110, 4'(k), 32'h100 + 32'(k));
            else if (k < 7) drive(1,0,0,1,1, 3'b101, 4'(k), 32'h100 + 32'(k));
            else            drive(1,0,0,0,1, 3'b000, 4'h0, 32'h0);
            pre();
            post();
        end

        // randomized traffic including mid-operation reset, freeze and flush
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 29) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0), 3'($urandom), 4'($urandom), $urandom);
            pre();
            post();
        end

        // fresh reset, fill DEPTH=3, then 5 cycles of in_valid while full
        drive(0,0,0,0,0, 3'b000, 4'h0, 32'h0);
        pre(); post();
        for (int k = 0; k < 8; k++) begin
            drive(1,0,0,1,0, 3'b100, 4'h1, 32'h200 + 32'(k));
            pre(); post();
        end
        drive(1,0,0,0,0, 3'b000, 4'h0, 32'h0);
        pre();
`ifdef MEM_WB_PERF_CNT_EN
        vectors++;
        if (stall3 !== 32'd5) begin
            miscompares++;
            $display("FAIL stall_full3: got %0d expected 5", stall3);
        end
        vectors++;
        if (stall2 !== 32'd6) begin
            miscompares++;
            $display("FAIL stall_full2: got %0d expected 6", stall2);
        end
`endif
        vectors++;
        if (occ3 !== 3'd3 || bus3.out_data !== 32'h200) begin
            miscompares++;
            $display("FAIL full3: got occ %0d data %h expected 3 00000200", occ3, bus3.out_data);
        end
        post();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
